// File: rtl/cc_pkg.sv
// Shared types and address-field helpers for the cache controller.
// No latency: declarations and pure functions only.
// No flow control in this file.
package cc_pkg;

    localparam int TAG_W  = 17;
    localparam int IDX_W  = 9;
    localparam int BEATS  = 8;
    localparam int BEAT_W = 3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOOKUP,
        ST_FILL_REQ,
        ST_FILL,
        ST_UPDATE,
        ST_READ_OUT
    } state_t;

    // Request fields in address order: tag | index | beat.
    typedef struct packed {
        logic [TAG_W-1:0]  tag;
        logic [IDX_W-1:0]  idx;
        logic [BEAT_W-1:0] beat;
    } req_t;

    // Split address bits [31:3] into tag, line index and starting beat.
    function automatic req_t addr_split(input logic [31:3] a);
        return '{tag: a[31:15], idx: a[14:6], beat: a[5:3]};
    endfunction

    // Byte address of the first beat of a line.
    function automatic logic [31:0] line_addr(input logic [TAG_W-1:0] tag,
                                              input logic [IDX_W-1:0] idx);
        return {tag, idx, 6'b0};
    endfunction

endpackage

// File: rtl/cc_beat_counter.sv
// Loadable 3-bit beat counter that wraps modulo 8.
// Count is visible the cycle after load/inc.
// No flow control; the owner gates inc.
module cc_beat_counter
    import cc_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [BEAT_W-1:0] load_val,
    input  logic              inc,
    output logic [BEAT_W-1:0] cnt
);

    // Load takes priority over increment; natural 3-bit overflow gives the wrap.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (inc) begin
            cnt <= cnt + BEAT_W'(1);
        end
    end

endmodule

// File: rtl/cc_ctrl_fsm.sv
// Read-only cache controller: tag lookup, line fill on miss, critical-word-first read-out.
// Hit: first data beat two cycles after request accept; miss adds fill latency.
// Accepts one request at a time (arready only in IDLE); read-out stalls on rready low.
module cc_ctrl_fsm #(
    parameter int TAG_W = 17,
    parameter int IDX_W = 9,
    parameter int BEATS = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   inct_arvalid_i,
    output logic                   inct_arready_o,
    input  logic [31:0]            inct_araddr_i,
    output logic                   inct_rvalid_o,
    input  logic                   inct_rready_i,
    output logic [63:0]            inct_rdata_o,
    output logic                   inct_rlast_o,
    output logic                   tag_ren_o,
    output logic                   tag_wen_o,
    output logic [IDX_W-1:0]       tag_addr_o,
    output logic [TAG_W:0]         tag_wdata_o,
    output logic                   hs_pulse_o,
    input  logic                   hit_i,
    input  logic                   miss_i,
    output logic                   data_ren_o,
    output logic                   data_wen_o,
    output logic [IDX_W+2:0]       data_addr_o,
    output logic [63:0]            data_wdata_o,
    input  logic [63:0]            data_rdata_i,
    output logic                   mem_arvalid_o,
    input  logic                   mem_arready_i,
    output logic [31:0]            mem_araddr_o,
    input  logic                   mem_rvalid_i,
    output logic                   mem_rready_o,
    input  logic [63:0]            mem_rdata_i,
    input  logic                   mem_rlast_i
);
    import cc_pkg::*;

    state_t            state_q, state_d;
    req_t              req_q, req_in;
    logic [BEAT_W-1:0] fill_cnt, rd_cnt, rd_nxt;
    logic              fill_load, fill_inc, rd_load, rd_inc;
    logic              ar_hs, last_beat;
    // Address byte offset and the memory's rlast are deliberately not used:
    // the fill is terminated by its own beat count.
    logic              unused_ok;

    assign unused_ok = ^{inct_araddr_i[2:0], mem_rlast_i};
    assign req_in    = addr_split(inct_araddr_i[31:3]);
    assign ar_hs     = inct_arvalid_i & inct_arready_o;
    assign rd_nxt    = rd_cnt + BEAT_W'(1);
    // The 8th beat is the one just before the sequence wraps back to the start beat.
    assign last_beat = (rd_nxt == req_q.beat);

    // State register and request capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            req_q   <= '0;
        end else begin
            state_q <= state_d;
            if (ar_hs) begin
                req_q <= req_in;
            end
        end
    end

    cc_beat_counter u_fill_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (fill_load),
        .load_val ({BEAT_W{1'b0}}),
        .inc      (fill_inc),
        .cnt      (fill_cnt)
    );

    cc_beat_counter u_rd_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (rd_load),
        .load_val (req_q.beat),
        .inc      (rd_inc),
        .cnt      (rd_cnt)
    );

    // Next state and all outputs; every control output is forced low during reset.
    always_comb begin
        state_d        = state_q;
        inct_arready_o = 1'b0;
        inct_rvalid_o  = 1'b0;
        inct_rlast_o   = 1'b0;
        inct_rdata_o   = data_rdata_i;
        tag_ren_o      = 1'b0;
        tag_wen_o      = 1'b0;
        tag_addr_o     = req_q.idx;
        tag_wdata_o    = {1'b1, req_q.tag};
        hs_pulse_o     = 1'b0;
        data_ren_o     = 1'b0;
        data_wen_o     = 1'b0;
        data_addr_o    = {req_q.idx, rd_cnt};
        data_wdata_o   = mem_rdata_i;
        mem_arvalid_o  = 1'b0;
        mem_araddr_o   = line_addr(req_q.tag, req_q.idx);
        mem_rready_o   = 1'b0;
        fill_load      = 1'b0;
        fill_inc       = 1'b0;
        rd_load        = 1'b0;
        rd_inc         = 1'b0;

        if (rst) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    inct_arready_o = 1'b1;
                    tag_addr_o     = req_in.idx;
                    if (inct_arvalid_i) begin
                        tag_ren_o  = 1'b1;
                        hs_pulse_o = 1'b1;
                        state_d    = ST_LOOKUP;
                    end
                end
                ST_LOOKUP: begin
                    if (hit_i && !miss_i) begin
                        data_ren_o  = 1'b1;
                        data_addr_o = {req_q.idx, req_q.beat};
                        rd_load     = 1'b1;
                        state_d     = ST_READ_OUT;
                    end else begin
                        state_d = ST_FILL_REQ;
                    end
                end
                ST_FILL_REQ: begin
                    mem_arvalid_o = 1'b1;
                    if (mem_arready_i) begin
                        fill_load = 1'b1;
                        state_d   = ST_FILL;
                    end
                end
                ST_FILL: begin
                    mem_rready_o = 1'b1;
                    if (mem_rvalid_i) begin
                        data_wen_o  = 1'b1;
                        data_addr_o = {req_q.idx, fill_cnt};
                        fill_inc    = 1'b1;
                        if (fill_cnt == BEAT_W'(BEATS - 1)) begin
                            state_d = ST_UPDATE;
                        end
                    end
                end
                ST_UPDATE: begin
                    tag_wen_o   = 1'b1;
                    data_ren_o  = 1'b1;
                    data_addr_o = {req_q.idx, req_q.beat};
                    rd_load     = 1'b1;
                    state_d     = ST_READ_OUT;
                end
                ST_READ_OUT: begin
                    inct_rvalid_o = 1'b1;
                    inct_rlast_o  = last_beat;
                    if (inct_rready_i) begin
                        if (last_beat) begin
                            state_d = ST_IDLE;
                        end else begin
                            data_ren_o  = 1'b1;
                            data_addr_o = {req_q.idx, rd_nxt};
                            rd_inc      = 1'b1;
                        end
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cc_ctrl_fsm.sv
module tb_cc_ctrl_fsm;

    logic        clk = 1'b0;
    logic        rst;
    logic        inct_arvalid_i, inct_arready_o;
    logic [31:0] inct_araddr_i;
    logic        inct_rvalid_o, inct_rready_i, inct_rlast_o;
    logic [63:0] inct_rdata_o;
    logic        tag_ren_o, tag_wen_o, hs_pulse_o, hit_i, miss_i;
    logic [8:0]  tag_addr_o;
    logic [17:0] tag_wdata_o;
    logic        data_ren_o, data_wen_o;
    logic [11:0] data_addr_o;
    logic [63:0] data_wdata_o, data_rdata_i;
    logic        mem_arvalid_o, mem_arready_i, mem_rvalid_i, mem_rready_o, mem_rlast_i;
    logic [31:0] mem_araddr_o;
    logic [63:0] mem_rdata_i;

    always #5 clk = ~clk;

    cc_ctrl_fsm dut (
        .clk(clk), .rst(rst),
        .inct_arvalid_i(inct_arvalid_i), .inct_arready_o(inct_arready_o), .inct_araddr_i(inct_araddr_i),
        .inct_rvalid_o(inct_rvalid_o), .inct_rready_i(inct_rready_i), .inct_rdata_o(inct_rdata_o),
        .inct_rlast_o(inct_rlast_o),
        .tag_ren_o(tag_ren_o), .tag_wen_o(tag_wen_o), .tag_addr_o(tag_addr_o), .tag_wdata_o(tag_wdata_o),
        .hs_pulse_o(hs_pulse_o), .hit_i(hit_i), .miss_i(miss_i),
        .data_ren_o(data_ren_o), .data_wen_o(data_wen_o), .data_addr_o(data_addr_o),
        .data_wdata_o(data_wdata_o), .data_rdata_i(data_rdata_i),
        .mem_arvalid_o(mem_arvalid_o), .mem_arready_i(mem_arready_i), .mem_araddr_o(mem_araddr_o),
        .mem_rvalid_i(mem_rvalid_i), .mem_rready_o(mem_rready_o), .mem_rdata_i(mem_rdata_i),
        .mem_rlast_i(mem_rlast_i)
    );

    int n_assert = 0;
    int n_fail   = 0;

    // Environment storage: tag and data SRAMs driven by the DUT.
    logic [17:0] tsram [512];
    logic [63:0] dsram [4096];
    // Reference model: which line each index is expected to hold.
    logic        mvalid [512];
    logic [16:0] mtag   [512];
    bit          force_en;
    logic [1:0]  force_val;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Contents of backing memory: unique per line and beat.
    function automatic logic [63:0] backing(input logic [31:0] line, input logic [2:0] beat);
        return {line, 24'hC0FFEE, 5'd0, beat};
    endfunction

    // One clock: capture DUT requests, apply SRAM/comparator responses after the edge.
    task automatic tick();
        logic        d_ren, d_wen, t_ren, t_wen, hs;
        logic [11:0] d_addr;
        logic [63:0] d_wdata;
        logic [8:0]  t_addr;
        logic [17:0] t_wdata, ent;
        logic [16:0] req_tag;
        d_ren = data_ren_o; d_wen = data_wen_o; d_addr = data_addr_o; d_wdata = data_wdata_o;
        t_ren = tag_ren_o;  t_wen = tag_wen_o;  t_addr = tag_addr_o;  t_wdata = tag_wdata_o;
        hs = hs_pulse_o; req_tag = inct_araddr_i[31:15];
        ent = t_ren ? tsram[t_addr] : 18'h0;
        @(posedge clk);
        #1;
        if (d_wen) dsram[d_addr] = d_wdata;
        if (t_wen) tsram[t_addr] = t_wdata;
        if (d_ren) data_rdata_i = dsram[d_addr];
        if (hs) begin
            hit_i  = ent[17] && (ent[16:0] == req_tag);
            miss_i = !hit_i;
            if (force_en) {hit_i, miss_i} = force_val;
        end else begin
            hit_i  = 1'b0;
            miss_i = 1'b0;
        end
        @(negedge clk);
    endtask

    task automatic chk_quiet(input string pfx);
        chk({pfx, "_arready"}, inct_arready_o, 0);
        chk({pfx, "_rvalid"}, inct_rvalid_o, 0);
        chk({pfx, "_rlast"}, inct_rlast_o, 0);
        chk({pfx, "_tag_en"}, {tag_ren_o, tag_wen_o, hs_pulse_o}, 0);
        chk({pfx, "_data_en"}, {data_ren_o, data_wen_o}, 0);
        chk({pfx, "_mem"}, {mem_arvalid_o, mem_rready_o}, 0);
    endtask

    // One upstream request from issue to the idle cycle after its last beat.
    task automatic do_req(input logic [31:0] addr, input int rr_mode, input bit early_rlast,
                          input bit hold_next, input logic [31:0] next_addr, input int rst_after,
                          input bit f_en, input logic [1:0] f_val);
        logic [31:0] line;
        logic [8:0]  idx;
        logic [16:0] tag;
        logic [2:0]  start, bb;
        logic [17:0] tag_before;
        logic [63:0] prev_rdata;
        bit exp_hit, done, fill_act, stalled, aborted;
        int cyc, b, wcnt, sent, n_ar, n_tw, stall_left;
        line = {addr[31:6], 6'd0}; idx = addr[14:6]; tag = addr[31:15]; start = addr[5:3];
        exp_hit = mvalid[idx] && (mtag[idx] == tag) && !f_en;
        force_en = f_en; force_val = f_val;
        done = 0; fill_act = 0; stalled = 0; aborted = 0; prev_rdata = '0;
        b = 0; wcnt = 0; sent = 0; n_ar = 0; n_tw = 0; stall_left = 3;
        tag_before = tsram[idx];
        inct_arvalid_i = 1'b1; inct_araddr_i = addr;
        #1;
        cyc = 0;
        while (inct_arready_o !== 1'b1 && cyc < 100) begin tick(); cyc++; end
        chk("accept_rdy", inct_arready_o, 1);
        chk("hs_pulse", hs_pulse_o, 1);
        chk("tag_ren", tag_ren_o, 1);
        chk("tag_raddr", tag_addr_o, idx);
        tick();
        inct_arvalid_i = hold_next;
        inct_araddr_i  = hold_next ? next_addr : addr;
        cyc = 0;
        while (!done && cyc < 400) begin
            cyc++;
            if (rst_after >= 0 && wcnt == rst_after) begin
                rst = 1'b1; mem_rvalid_i = 1'b0; mem_arready_i = 1'b0; inct_rready_i = 1'b0;
                #1;
                chk_quiet("rst_fill");
                tick();
                rst = 1'b0;
                tick();
                chk("arready_post_rst", inct_arready_o, 1);
                chk("tag_kept", tsram[idx], tag_before);
                aborted = 1; done = 1;
                break;
            end
            if (fill_act && sent < 8 && $urandom_range(0, 3) != 0) begin
                mem_rvalid_i = 1'b1;
                mem_rdata_i  = backing(line, 3'(sent));
                mem_rlast_i  = early_rlast ? (sent == 3) : (sent == 7);
            end else begin
                mem_rvalid_i = 1'b0;
                mem_rlast_i  = 1'b0;
                mem_rdata_i  = {$urandom, $urandom};
            end
            mem_arready_i = mem_arvalid_o ? 1'($urandom_range(0, 1)) : 1'b0;
            case (rr_mode)
                0: inct_rready_i = 1'b1;
                1: inct_rready_i = 1'($urandom_range(0, 1));
                default: begin
                    if (inct_rvalid_o && b == 3 && stall_left > 0) begin
                        inct_rready_i = 1'b0; stall_left--;
                    end else inct_rready_i = 1'b1;
                end
            endcase
            #1;
            chk("arready_busy", inct_arready_o, 0);
            if (mem_arvalid_o) chk("mem_araddr", mem_araddr_o, line);
            if (mem_arvalid_o && mem_arready_i) begin n_ar++; fill_act = 1; end
            if (mem_rvalid_i && mem_rready_o) sent++;
            if (data_wen_o) begin
                chk("wr_addr", data_addr_o, {idx, 3'(wcnt)});
                chk("wr_data", data_wdata_o, backing(line, 3'(wcnt)));
                wcnt++;
            end
            if (tag_wen_o) begin
                n_tw++;
                chk("tag_waddr", tag_addr_o, idx);
                chk("tag_wdata", tag_wdata_o, {1'b1, tag});
            end
            if (data_ren_o || data_wen_o) chk("data_rw_excl", data_ren_o & data_wen_o, 0);
            if (tag_ren_o || tag_wen_o)   chk("tag_rw_excl", tag_ren_o & tag_wen_o, 0);
            if (stalled) begin
                chk("stall_vld", inct_rvalid_o, 1);
                chk("stall_dat", inct_rdata_o, prev_rdata);
            end
            if (inct_rvalid_o && !inct_rready_i) chk("stall_noren", data_ren_o, 0);
            if (inct_rvalid_o) begin
                bb = start + 3'(b);
                chk("rdata", inct_rdata_o, backing(line, bb));
                chk("rlast", inct_rlast_o, b == 7);
                stalled = !inct_rready_i;
                prev_rdata = inct_rdata_o;
                if (inct_rready_i) begin
                    b++;
                    if (b == 8) done = 1;
                end
            end else stalled = 0;
            tick();
        end
        mem_rvalid_i = 1'b0; mem_arready_i = 1'b0; mem_rlast_i = 1'b0;
        chk("txn_done", done, 1);
        if (aborted) begin
            chk("rst_tag_writes", n_tw, 0);
        end else begin
            chk("arready_after", inct_arready_o, 1);
            chk("mem_ar_cnt", n_ar, exp_hit ? 0 : 1);
            chk("fill_writes", wcnt, exp_hit ? 0 : 8);
            chk("tag_writes", n_tw, exp_hit ? 0 : 1);
            if (!exp_hit) begin mvalid[idx] = 1'b1; mtag[idx] = tag; end
        end
        force_en = 0;
    endtask

    initial begin
        logic [31:0] a;
        rst = 1'b1; inct_arvalid_i = 0; inct_araddr_i = 0; inct_rready_i = 0;
        hit_i = 0; miss_i = 0; data_rdata_i = 0; mem_arready_i = 0; mem_rvalid_i = 0;
        mem_rdata_i = 0; mem_rlast_i = 0; force_en = 0; force_val = 0;
        for (int i = 0; i < 512; i++) begin tsram[i] = '0; mvalid[i] = 0; mtag[i] = '0; end
        for (int i = 0; i < 4096; i++) dsram[i] = '0;
        // Line 0x8040 (tag 1, index 1) is resident before the test starts.
        tsram[1] = {1'b1, 17'd1}; mvalid[1] = 1'b1; mtag[1] = 17'd1;
        for (int i = 0; i < 8; i++) dsram[{9'd1, 3'(i)}] = backing(32'h0000_8040, 3'(i));

        @(negedge clk);
        tick(); tick();
        chk_quiet("reset");
        rst = 1'b0;
        tick();
        chk("arready_first", inct_arready_o, 1);

        do_req(32'h0000_8040, 0, 0, 0, 0, -1, 0, 2'b00);           // hit, start beat 0
        do_req(32'h0000_8048, 0, 0, 0, 0, -1, 0, 2'b00);           // hit, beats 1..7,0
        do_req(32'h0001_0080, 0, 0, 0, 0, -1, 0, 2'b00);           // miss and fill of index 2
        do_req(32'h0001_00B8, 2, 0, 0, 0, -1, 0, 2'b00);           // hit with 3-cycle stall
        do_req(32'h0003_00C0, 2, 1, 0, 0, -1, 0, 2'b00);           // miss, early rlast
        do_req(32'h0002_0080, 0, 0, 0, 0, 3, 0, 2'b00);            // reset after 3 fill beats
        do_req(32'h0001_0080, 0, 0, 0, 0, -1, 1, 2'b00);           // forced miss refills index 2
        do_req(32'h0001_0088, 0, 0, 1, 32'h0000_8050, -1, 0, 2'b00); // next request held
        do_req(32'h0000_8050, 0, 0, 0, 0, -1, 0, 2'b00);
        do_req(32'h0000_8040, 1, 0, 0, 0, -1, 1, 2'b11);           // hit and miss both set

        for (int n = 0; n < 40; n++) begin
            a = {17'($urandom_range(1, 3)), 9'($urandom_range(0, 5)), 6'($urandom)};
            do_req(a, $urandom_range(0, 2), 1'($urandom_range(0, 1)), 0, 0, -1, 0, 2'b00);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
